// File: rtl/upscaler_pkg.sv
// upscaler_pkg: shared pixel/state types and fixed-point step helper for the upscaler
package upscaler_pkg;
  typedef logic [31:0] pixel_t;
  typedef enum logic {FILL, EMIT} upscale_state_t;
  function automatic logic [31:0] step_calc(input int src, input int dst, input int frac);
    return 32'((64'(src) << frac) / 64'(dst));
  endfunction
endpackage

// File: rtl/upscaler_linebuf.sv
// upscaler_linebuf: one-row pixel store, registered write and combinational read
module upscaler_linebuf
  import upscaler_pkg::*;
#(
  parameter int DEPTH = 160,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);
  pixel_t mem [DEPTH];
  // store the incoming source pixel; contents are never reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/stream_upscaler.sv
// stream_upscaler: nearest-neighbour row-buffered upscaler; optional STREAM_UPSCALER_FRAME_MARKERS_EN adds out_sof/out_eol
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 640
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 480
`endif
module stream_upscaler
  import upscaler_pkg::*;
#(
  parameter int SRC_W = 160,
  parameter int SRC_H = 120,
  parameter int DST_W = `LAPTOP_WIDTH,
  parameter int DST_H = `LAPTOP_HEIGHT,
  parameter int FRAC = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        frame_done
`ifdef STREAM_UPSCALER_FRAME_MARKERS_EN
  ,
  output logic        out_sof,
  output logic        out_eol
`endif
);
  localparam int AW = $clog2(SRC_W > 1 ? SRC_W : 2);
  localparam int RW = $clog2(SRC_H > 1 ? SRC_H : 2);
  localparam int XW = $clog2(DST_W > 1 ? DST_W : 2);
  localparam int YW = $clog2(DST_H > 1 ? DST_H : 2);
  localparam logic [31:0] STEP_X = step_calc(SRC_W, DST_W, FRAC);
  localparam logic [31:0] STEP_Y = step_calc(SRC_H, DST_H, FRAC);
  upscale_state_t state;
  logic [AW-1:0] wr_x;
  logic [XW-1:0] dst_x;
  logic [YW-1:0] dst_y;
  logic [RW-1:0] cur_row;
  logic [31:0] acc_x, acc_y, ny;
  logic in_hs, out_hs, last_wr, last_x, last_y;
  assign in_ready  = state == FILL;
  assign out_valid = state == EMIT;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_wr   = wr_x == AW'(SRC_W - 1);
  assign last_x    = dst_x == XW'(DST_W - 1);
  assign last_y    = dst_y == YW'(DST_H - 1);
  assign ny        = acc_y + STEP_Y;
  assign frame_done = out_hs & last_x & last_y;
`ifdef STREAM_UPSCALER_FRAME_MARKERS_EN
  assign out_sof = out_valid & dst_x == '0 & dst_y == '0;
  assign out_eol = out_valid & last_x;
`endif
  upscaler_linebuf #(.DEPTH(SRC_W), .AW(AW)) u_linebuf (
    .clk  (clock),
    .we   (in_hs),
    .waddr(wr_x),
    .wdata(in_data),
    .raddr(acc_x[FRAC +: AW]),
    .rdata(out_data)
  );
  // fill/emit sequencing; all counters move only on handshakes
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FILL;
      wr_x    <= '0;
      dst_x   <= '0;
      dst_y   <= '0;
      cur_row <= '0;
      acc_x   <= '0;
      acc_y   <= '0;
    end else begin
      if (in_hs) begin
        wr_x <= last_wr ? '0 : wr_x + 1'b1;
        if (last_wr) state <= EMIT;
      end
      if (out_hs) begin
        dst_x <= last_x ? '0 : dst_x + 1'b1;
        acc_x <= last_x ? '0 : acc_x + STEP_X;
        if (last_x && last_y) begin
          acc_y   <= '0;
          dst_y   <= '0;
          cur_row <= '0;
          state   <= FILL;
        end else if (last_x) begin
          acc_y <= ny;
          dst_y <= dst_y + 1'b1;
          if ((ny >> FRAC) != 32'(cur_row)) begin
            cur_row <= cur_row + 1'b1;
            state   <= FILL;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_stream_upscaler.sv
// tb_stream_upscaler: randomized self-checking bench against a nearest-neighbour reference model
module tb_stream_upscaler;
  logic clk = 0;
  logic rst = 1;
  logic iv [4], ir [4], ov [4], ordy [4], fd [4];
  logic [31:0] id [4], od [4];
`ifdef STREAM_UPSCALER_FRAME_MARKERS_EN
  logic sof [4], eol [4];
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

`ifdef STREAM_UPSCALER_FRAME_MARKERS_EN
  `define TB_MK(k) , .out_sof(sof[k]), .out_eol(eol[k])
`else
  `define TB_MK(k)
`endif

  stream_upscaler #(.SRC_W(2), .SRC_H(2), .DST_W(4), .DST_H(4), .FRAC(16)) u0 (
    .clock(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .frame_done(fd[0]) `TB_MK(0));
  stream_upscaler #(.SRC_W(2), .SRC_H(2), .DST_W(3), .DST_H(3), .FRAC(16)) u1 (
    .clock(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .frame_done(fd[1]) `TB_MK(1));
  stream_upscaler #(.SRC_W(3), .SRC_H(2), .DST_W(7), .DST_H(5), .FRAC(16)) u2 (
    .clock(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .frame_done(fd[2]) `TB_MK(2));
  stream_upscaler #(.SRC_W(3), .SRC_H(2), .DST_W(3), .DST_H(2), .FRAC(16)) u3 (
    .clock(clk), .reset(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .frame_done(fd[3]) `TB_MK(3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready", ir[k], 1);
      check("rst_out_valid", ov[k], 0);
      check("rst_frame_done", fd[k], 0);
`ifdef STREAM_UPSCALER_FRAME_MARKERS_EN
      check("rst_sof", sof[k], 0);
      check("rst_eol", eol[k], 0);
`endif
    end
  endtask

  // Drives one stream into DUT k while collecting its outputs against the reference image.
  // rmode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready. stop_after>0 aborts early.
  task automatic run(input int k, input int sw, input int sh, input int dw, input int dh,
                     input int nfr, input int rmode, input bit gaps, input int stop_after,
                     input logic [31:0] src[$]);
    logic [31:0] exp[$];
    logic [31:0] pod = '0;
    int stx = (sw << 16) / dw;
    int sty = (sh << 16) / dh;
    int ip = 0, op = 0, cyc = 0, emits = 0, dones = 0, total, n;
    bit pst = 0, pov = 0;
    n = dw * dh;
    for (int f = 0; f < nfr; f++)
      for (int y = 0; y < dh; y++)
        for (int x = 0; x < dw; x++)
          exp.push_back(src[f * sw * sh + ((y * sty) >> 16) * sw + ((x * stx) >> 16)]);
    total = stop_after > 0 ? stop_after : nfr * n;
    while (op < total && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      iv[k] = ip < src.size() && (!gaps || $urandom_range(0, 2) != 0);
      id[k] = iv[k] ? src[ip] : $urandom;
      ordy[k] = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 1 || cyc % 4 == 0) : 1'($urandom_range(0, 1));
      #1;
      check("exclusive", {31'd0, ir[k] & ov[k]}, 0);
      if (pst) begin
        check("stall_valid", ov[k], 1);
        check("stall_data", od[k], pod);
      end
      if (ov[k] && !pov) emits++;
      if (ov[k] && ordy[k]) begin
        check("data", od[k], exp[op]);
        check("frame_done", fd[k], (op % n) == n - 1);
`ifdef STREAM_UPSCALER_FRAME_MARKERS_EN
        check("sof", sof[k], (op % n) == 0);
        check("eol", eol[k], (op % dw) == dw - 1);
`endif
        dones += int'(fd[k]);
        op++;
      end else begin
        check("frame_done_idle", fd[k], 0);
`ifdef STREAM_UPSCALER_FRAME_MARKERS_EN
        if (!ov[k]) begin
          check("sof_idle", sof[k], 0);
          check("eol_idle", eol[k], 0);
        end
`endif
      end
      if (iv[k] && ir[k]) ip++;
      pst = ov[k] && !ordy[k];
      pov = ov[k];
      pod = od[k];
    end
    @(negedge clk);
    iv[k] = 0;
    ordy[k] = 0;
    check("outputs_seen", op, total);
    if (stop_after == 0) begin
      check("inputs_used", ip, src.size());
      check("emit_phases", emits, nfr * sh);
      check("frame_count", dones, nfr);
    end
  endtask

  initial begin
    logic [31:0] q[$];
    for (int k = 0; k < 4; k++) begin
      iv[k] = 0;
      ordy[k] = 0;
      id[k] = '0;
    end
    do_reset();
    q = {32'd1, 32'd2, 32'd3, 32'd4};
    run(0, 2, 2, 4, 4, 1, 0, 0, 0, q);
    run(1, 2, 2, 3, 3, 1, 0, 0, 0, q);
    run(0, 2, 2, 4, 4, 1, 1, 1, 0, q);
    run(0, 2, 2, 4, 4, 1, 0, 0, 5, q);
    do_reset();
    q = {32'd9, 32'd8, 32'd7, 32'd6};
    run(0, 2, 2, 4, 4, 1, 0, 0, 0, q);
    q = {};
    for (int i = 0; i < 8; i++) q.push_back($urandom);
    run(0, 2, 2, 4, 4, 2, 0, 0, 0, q);
    q = {};
    for (int i = 0; i < 12; i++) q.push_back($urandom);
    run(2, 3, 2, 7, 5, 2, 2, 1, 0, q);
    q = {};
    for (int i = 0; i < 6; i++) q.push_back($urandom);
    run(3, 3, 2, 3, 2, 1, 2, 1, 0, q);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
